// File: rtl/fpm_pipe.sv
// fpm_pipe: three-stage pipelined floating-point multiplier.
//   S1 unpacks and classifies the operands and forms the biased exponent sum.
//   S2 forms the full significand product.
//   S3 normalises, rounds to nearest-even, resolves special cases and packs.
// Subnormal inputs are read as zero, and results that underflow are flushed
// to zero. A single global stall freezes the whole pipe while the output is
// blocked, so bubbles are never compressed.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; a, b operands; in_tag carried tag
//   out_valid/out_ready result handshake; out product; out_tag matching tag
//   flag_ovf/unf/inv    overflow, flush-to-zero and invalid flags for out
module fpm_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_inv
);

  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Result-level special cases, already resolved from the operand classes.
  typedef struct packed {
    logic nan;
    logic inv;
    logic inf;
    logic zero;
  } spec_t;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------- S1: unpack / classify ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             inf_x_zero;
  spec_t            spec_n;
  logic signed [EW-1:0] esum_n;

  always_comb begin
    ea = a[W-2 -: EXP_W];
    eb = b[W-2 -: EXP_W];
    fa = a[MAN_W-1:0];
    fb = b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    inf_x_zero = (a_inf && b_zero) || (a_zero && b_inf);
    spec_n.nan  = a_nan || b_nan || inf_x_zero;
    // Quiet NaN inputs propagate silently; signalling ones raise invalid.
    spec_n.inv  = inf_x_zero || (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
    spec_n.inf  = a_inf || b_inf;
    spec_n.zero = a_zero || b_zero;
    esum_n = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
  end

  logic                 s1_v, s2_v;
  logic                 s1_sign, s2_sign;
  spec_t                s1_spec, s2_spec;
  logic signed [EW-1:0] s1_exp, s2_exp;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic [PW-1:0]        s2_prod;
  logic [TAG_W-1:0]     s1_tag, s2_tag;

  // Datapath registers carry no reset; only the valids qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign <= a[W-1] ^ b[W-1];
      s1_spec <= spec_n;
      s1_exp  <= esum_n;
      s1_ma   <= {1'b1, fa};
      s1_mb   <= {1'b1, fb};
      s1_tag  <= in_tag;
      // ---------------- S2: multiply ----------------
      s2_sign <= s1_sign;
      s2_spec <= s1_spec;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_tag  <= s1_tag;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic                 hi, guard, sticky, rnd;
  logic [MAN_W-1:0]     frac_t;
  logic [MAN_W:0]       frac_r;
  logic signed [EW-1:0] e_f;
  logic                 ovf, unf;
  logic [W-1:0]         res;
  logic                 res_ovf, res_unf, res_inv;

  always_comb begin
    hi = s2_prod[PW-1];
    if (hi) begin
      frac_t = s2_prod[PW-2 -: MAN_W];
      guard  = s2_prod[MAN_W];
      sticky = |s2_prod[MAN_W-1:0];
    end else begin
      frac_t = s2_prod[PW-3 -: MAN_W];
      guard  = s2_prod[MAN_W-1];
      sticky = |s2_prod[MAN_W-2:0];
    end
    rnd    = guard && (sticky || frac_t[0]);
    frac_r = {1'b0, frac_t} + (MAN_W+1)'(rnd);
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    e_f = s2_exp + $signed({{(EW-1){1'b0}}, hi}) + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});
    ovf = (e_f >= EMAX_E);
    unf = e_f[EW-1] || (e_f == '0);

    res     = '0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_inv = 1'b0;
    if (s2_spec.nan) begin
      res     = QNAN;
      res_inv = s2_spec.inv;
    end else if (s2_spec.inf) begin
      res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_spec.zero) begin
      res = {s2_sign, {(W-1){1'b0}}};
    end else if (ovf) begin
      res     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (unf) begin
      res     = {s2_sign, {(W-1){1'b0}}};
      res_unf = 1'b1;
    end else begin
      res = {s2_sign, e_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (!stall) begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      // Bubbles leave a clean zero word behind instead of stale datapath bits.
      out       <= s2_v ? res : '0;
      out_tag   <= s2_v ? s2_tag : '0;
      flag_ovf  <= s2_v && res_ovf;
      flag_unf  <= s2_v && res_unf;
      flag_inv  <= s2_v && res_inv;
    end
  end

endmodule

// File: tb/tb_fpm_pipe.sv
// Directed bench for fpm_pipe with a result scoreboard.
module tb_fpm_pipe;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [TAG_W-1:0] out_tag;
  logic             flag_ovf, flag_unf, flag_inv;

  always #5 clk = ~clk;

  fpm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_tag(out_tag),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
  );

  typedef struct {
    logic [W-1:0]     res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flg;   // {ovf, unf, inv}
    int               due;
    bit               chk_lat;
    int               id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   nid      = 0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every output transfer must match the oldest entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out: got out=%h tag=%h, want no result", out, out_tag);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        assert (out === mon_e.res) else begin
          failures++;
          $error("FAIL op%0d_out: got %h want %h", mon_e.id, out, mon_e.res);
        end
        checks++;
        assert (out_tag === mon_e.tag) else begin
          failures++;
          $error("FAIL op%0d_tag: got %h want %h", mon_e.id, out_tag, mon_e.tag);
        end
        checks++;
        assert ({flag_ovf, flag_unf, flag_inv} === mon_e.flg) else begin
          failures++;
          $error("FAIL op%0d_flags: got %b want %b", mon_e.id,
                 {flag_ovf, flag_unf, flag_inv}, mon_e.flg);
        end
        if (mon_e.chk_lat) begin
          checks++;
          assert (cyc === mon_e.due) else begin
            failures++;
            $error("FAIL op%0d_latency: got cycle %0d want %0d", mon_e.id, cyc, mon_e.due);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one operand pair, wait (bounded) for acceptance, record the expectation.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic [TAG_W-1:0] tg, input logic [W-1:0] er,
                       input logic [2:0] ef, input bit lat, input bit push);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    a = ta; b = tbv; in_tag = tg; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL accept_timeout: got in_ready=%b want 1 within 40 cycles", in_ready);
    end
    if (ok && push) begin
      e.res = er; e.tag = tg; e.flg = ef; e.due = cyc + 3; e.chk_lat = lat; e.id = nid;
      sb.push_back(e);
    end
    nid++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain: got %0d results outstanding want 0", sb.size());
    end
  endtask

  task automatic check_idle_out(input int step);
    checks++;
    assert ({out_valid, out, out_tag, flag_ovf, flag_unf, flag_inv} === '0) else begin
      failures++;
      $error("FAIL reset_state%0d: got valid=%b out=%h tag=%h flags=%b want all zero", step,
             out_valid, out, out_tag, {flag_ovf, flag_unf, flag_inv});
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      failures++;
      $error("FAIL reset_ready%0d: got %b want 1", step, in_ready);
    end
  endtask

  // Special cases and rounding boundaries: {a, b, expected, flags {ovf,unf,inv}}.
  logic [W-1:0] sp_a [16] = '{16'h7800, 16'h7C00, 16'h7E00, 16'h0400, 16'h0001, 16'h7C01,
                              16'h7C00, 16'h8000, 16'h3E00, 16'h3C01, 16'h3C03, 16'h3DA8,
                              16'h0400, 16'h7800, 16'h7BFF, 16'hFE00};
  logic [W-1:0] sp_b [16] = '{16'h4000, 16'h0000, 16'h3C00, 16'h3800, 16'h3C00, 16'h3C00,
                              16'hC000, 16'h4000, 16'h3E00, 16'h3E00, 16'h3E00, 16'h3DA8,
                              16'h3C00, 16'h3C00, 16'h3C01, 16'h4000};
  logic [W-1:0] sp_r [16] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'h0000, 16'h0000, 16'h7E00,
                              16'hFC00, 16'h8000, 16'h4080, 16'h3E02, 16'h3E04, 16'h4000,
                              16'h0400, 16'h7800, 16'h7C00, 16'h7E00};
  logic [2:0]   sp_f [16] = '{3'b100, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001,
                              3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b100, 3'b000};

  // Backpressure stream.
  logic [W-1:0] bp_a [5] = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800, 16'h4500};
  logic [W-1:0] bp_b [5] = '{16'h3C00, 16'h4200, 16'h4000, 16'h3800, 16'h4000};
  logic [W-1:0] bp_r [5] = '{16'h3C00, 16'h4600, 16'hC400, 16'h3400, 16'h4900};

  logic [W-1:0]     held_out;
  logic [TAG_W-1:0] held_tag;
  bit               seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    check_idle_out(0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic product.
    issue(16'h4300, 16'h4480, 4'd5, 16'h4BE0, 3'b000, 1'b1, 1'b1);
    drain();

    // Sign and back-to-back streaming.
    issue(16'hC000, 16'h3800, 4'd1, 16'hBC00, 3'b000, 1'b1, 1'b1);
    issue(16'h3C01, 16'h3C01, 4'd2, 16'h3C02, 3'b000, 1'b1, 1'b1);
    issue(16'h4000, 16'h4000, 4'd3, 16'h4400, 3'b000, 1'b1, 1'b1);
    drain();

    // Specials, flags and rounding boundaries, streamed.
    for (int i = 0; i < 16; i++)
      issue(sp_a[i], sp_b[i], TAG_W'(i), sp_r[i], sp_f[i], 1'b1, 1'b1);
    drain();

    // Backpressure: hold out_ready low for 4 cycles from the first out_valid.
    fork
      begin
        for (int i = 0; i < 5; i++)
          issue(bp_a[i], bp_b[i], TAG_W'(i + 1), bp_r[i], 3'b000, 1'b0, 1'b1);
      end
      begin
        out_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        checks++;
        assert (seen === 1'b1) else begin
          failures++;
          $error("FAIL bp_first_valid: got out_valid=%b want 1 within 20 cycles", out_valid);
        end
        held_out = out;
        held_tag = out_tag;
        for (int k = 0; k < 4; k++) begin
          if (k != 0) @(negedge clk);
          checks++;
          assert (in_ready === 1'b0) else begin
            failures++;
            $error("FAIL bp_in_ready%0d: got %b want 0", k, in_ready);
          end
          checks++;
          assert ({out_valid, out, out_tag} === {1'b1, held_out, held_tag}) else begin
            failures++;
            $error("FAIL bp_hold%0d: got valid=%b out=%h tag=%h want 1/%h/%h", k,
                   out_valid, out, out_tag, held_out, held_tag);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight (output stalled so none leaves).
    out_ready = 1'b0;
    issue(16'h4000, 16'h4000, 4'd9, 16'h4400, 3'b000, 1'b0, 1'b0);
    issue(16'h4200, 16'h4200, 4'd10, 16'h4880, 3'b000, 1'b0, 1'b0);
    issue(16'h3C00, 16'h4500, 4'd11, 16'h4500, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_out(1);
    out_ready = 1'b1;
    idle(8);
    issue(16'h4300, 16'h4480, 4'd12, 16'h4BE0, 3'b000, 1'b1, 1'b1);
    drain();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpm_pipe.md
Name: fpm_pipe

Overview:
- Parametrised, pipelined IEEE-style floating-point multiplier; successor to the combinational half-precision fpm.
- Sits as a functional unit behind the scoreboard issue logic.
- Accepts operand pairs with a tag through a valid/ready handshake.
- Returns a rounded product, exception flags and the same tag a fixed 3 cycles later, with full backpressure support.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of the scoreboard tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  unit can accept this cycle.
- a  in  W  operand A {sign, exponent, fraction}.
- b  in  W  operand B.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out  out  W  rounded product.
- out_tag  out  TAG_W  tag of the result.
- flag_ovf  out  1  result overflowed to infinity.
- flag_unf  out  1  result flushed to zero.
- flag_inv  out  1  invalid operation (NaN result).

Behaviour:
- **Reset:** rst high at a clock edge clears all stage valids. out_valid=0, out=0, out_tag=0, all flags=0. rst overrides in_valid and discards in-flight operations.
- **Handshake:**
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - Global stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every stage register, out, out_tag and the flags hold.
  - Bubbles are not compressed.
- **Latency and throughput:** latency 3 cycles from accepted input to out_valid with no stall; throughput 1 operation per cycle.
- **S1 (unpack/classify):**
  - sign = a.s ^ b.s.
  - Classify each operand as zero (exp=0, any fraction), inf, NaN or normal. Subnormal inputs are treated as zero (DAZ).
  - Biased exponent sum computed as signed ea+eb-bias, width EXP_W+2.
- **S2 (multiply):** full (MAN_W+1)x(MAN_W+1) significand product, width 2*MAN_W+2.
- **S3 (normalise/round/pack):**
  - If the product MSB is set, shift right 1 and exponent+1.
  - Round to nearest, ties to even, using guard bit plus sticky OR of the remaining bits.
  - A rounding carry out of the significand increments the exponent again.
- **Specials, in priority order:**
  - Either operand NaN, or inf*zero → canonical quiet NaN (sign 0, exp all ones, fraction MSB 1, rest 0). flag_inv=1 only for inf*zero and signalling NaN (fraction MSB 0).
  - Either operand inf → inf with the computed sign.
  - Either operand zero → signed zero.
  - Final exponent >= 2^EXP_W-1 → signed inf, flag_ovf=1.
  - Final exponent <= 0 → signed zero, flag_unf=1 (FTZ, no subnormal outputs).
- **Flags:** qualify the current out; valid only when out_valid=1.
- **Tag:** passes through unchanged, aligned with its result.

Test Plan:
- **Basic product:** reset, then a=0x4300 (3.5), b=0x4480 (4.5), tag 5 → 3 cycles later out=0x4BE0 (15.75), out_tag=5, no flags.
- **Sign and streaming:** issue back-to-back 0xC000*0x3800, 0x3C01*0x3C01, 0x4000*0x4000 with out_ready=1 → out 0xBC00, 0x3C02, 0x4400 on consecutive cycles starting at cycle 3.
- **Overflow and invalid:**
  - 0x7800*0x4000 → 0x7C00, flag_ovf=1.
  - 0x7C00*0x0000 → 0x7E00, flag_inv=1.
  - 0x7E00*0x3C00 → 0x7E00, flag_inv=0.
- **Underflow:** 0x0400*0x3800 → 0x0000, flag_unf=1. Subnormal input 0x0001*0x3C00 → 0x0000, flag_unf=0.
- **Backpressure:**
  - Stream 5 operations, hold out_ready=0 for 4 cycles after the first out_valid.
  - in_ready=0 during the stall; out is held stable.
  - All 5 results appear in order with correct tags and no loss or duplication.
- **Reset mid-operation:** assert rst for 1 cycle with 3 operations in flight → out_valid=0 next cycle; no stale result ever emerges; a fresh operation afterwards returns at normal latency.
